// File: rtl/seq_shift_right_alu.sv
// Multi-cycle right shifter (logical/arithmetic), one bit position per clock,
// start/done handshake and the ALU-family flags of/cary/eq.
module seq_shift_right_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             arith,
   input  logic [WIDTH-1:0] a,
   input  logic [31:0]      b,
   output logic [WIDTH-1:0] s,
   output logic             of,
   output logic             cary,
   output logic             eq,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] work, a_save;
   logic [CNT_W-1:0] cnt, n_load;
   logic             mode, sticky, last_out, fill;

   // Any amount at or past WIDTH behaves exactly like WIDTH.
   always_comb begin
      if (b >= 32'(WIDTH)) n_load = CNT_W'(WIDTH);
      else                 n_load = b[CNT_W-1:0];
   end

   assign fill = mode & work[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = 1'b0;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (cnt == '0) state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work     <= '0;
         a_save   <= '0;
         cnt      <= '0;
         mode     <= 1'b0;
         sticky   <= 1'b0;
         last_out <= 1'b0;
         s        <= '0;
         of       <= 1'b0;
         cary     <= 1'b0;
         eq       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               work     <= a;
               a_save   <= a;
               mode     <= arith;
               cnt      <= n_load;
               sticky   <= 1'b0;
               last_out <= 1'b0;
            end
            SHIFT: begin
               if (cnt != '0) begin
                  last_out <= work[0];
                  sticky   <= sticky | work[0];
                  work     <= {fill, work[WIDTH-1:1]};
                  cnt      <= cnt - CNT_W'(1);
               end else begin
                  // Results only move here, so they hold between operations.
                  s    <= work;
                  cary <= last_out;
                  of   <= sticky;
                  eq   <= (work == a_save);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_right_alu.sv
// Randomized + directed bench for seq_shift_right_alu against a plain
// arithmetic reference (>> / >>> with clamped amount).
module tb_seq_shift_right_alu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         arith = 1'b0;
   logic [W-1:0] a = '0;
   logic [31:0]  b = '0;
   logic [W-1:0] s;
   logic         of, cary, eq, busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_shift_right_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .arith(arith), .a(a), .b(b),
      .s(s), .of(of), .cary(cary), .eq(eq), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic int clamp(input logic [31:0] bb);
      return (bb >= 32'(W)) ? W : int'(bb);
   endfunction

   // Reference: whole-word shift by the clamped amount; shifted-out bits are a[n-1:0].
   task automatic model(input logic [W-1:0] aa, input logic [31:0] bb, input logic ar,
                        output logic [W-1:0] es, output logic ec, output logic eo,
                        output logic ee);
      int n;
      logic [63:0] lost;
      n = clamp(bb);
      if (ar) es = W'($signed(aa) >>> n);
      else    es = aa >> n;
      lost = {32'h0, aa} & ((64'h1 << n) - 64'h1);
      eo = (lost != 64'h0);
      ec = (n == 0) ? 1'b0 : aa[n-1];
      ee = (es == aa);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] aa, input logic [31:0] bb,
                         input logic ar);
      logic [W-1:0] es;
      logic ec, eo, ee;
      int k, bcnt, n;
      model(aa, bb, ar, es, ec, eo, ee);
      n = clamp(bb);
      start = 1'b1; a = aa; b = bb; arith = ar;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; arith = $urandom_range(0, 1);
      bcnt = busy ? 1 : 0;
      k = 0;
      while (!done && k < 200) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         if (busy) bcnt++;
      end
      chk({tag, ".lat"}, 64'(k), 64'(n + 1));
      chk({tag, ".busy"}, 64'(bcnt), 64'(n + 2));
      chk({tag, ".s"}, 64'(s), 64'(es));
      chk({tag, ".flags"}, {61'h0, of, cary, eq}, {61'h0, eo, ec, ee});
      @(negedge clk);
      chk({tag, ".pulse"}, {62'h0, done, busy}, 64'h0);
   endtask

   initial begin
      logic [W-1:0] es, es2, ra;
      logic ec, eo, ee, ec2, eo2, ee2;
      logic [31:0] rb;
      int k, n1, n2, nd, d1, d2;

      repeat (2) @(negedge clk);
      chk("rst.out", {s, of, cary, eq, busy, done}, '0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("b1.log", 32'hFFFF_FFFF, 1, 1'b0);
      chk("b1.log.val", {s, of, cary, eq}, {32'h7FFF_FFFF, 3'b110});
      run_op("b1.ari", 32'hFFFF_FFFF, 1, 1'b1);
      chk("b1.ari.val", {s, of, cary, eq}, {32'hFFFF_FFFF, 3'b111});
      run_op("m10", 32'hFFFF_0000, 10, 1'b0);
      chk("m10.val", {s, of, cary, eq}, {32'h003F_FFC0, 3'b000});
      run_op("m2", 32'h0000_FFFF, 2, 1'b0);
      chk("m2.val", {s, of, cary}, {32'h0000_3FFF, 2'b11});
      run_op("cl32", 32'hAAAA_AAAA, 32, 1'b0);
      chk("cl32.val", {s, of, cary}, {32'h0, 2'b11});
      run_op("cl40", 32'hAAAA_AAAA, 40, 1'b0);
      chk("cl40.val", {s, of, cary}, {32'h0, 2'b11});
      run_op("cl40a", 32'hAAAA_AAAA, 40, 1'b1);
      chk("cl40a.val", {s, cary}, {32'hFFFF_FFFF, 1'b1});
      run_op("big", 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
      run_op("z", 32'h1234_5678, 0, 1'b0);
      chk("z.val", {s, of, cary, eq}, {32'h1234_5678, 3'b001});
      run_op("a0", 32'h0, 17, 1'b0);
      run_op("a1s", 32'hFFFF_FFFF, 23, 1'b1);

      // start held high throughout: ignored during SHIFT/DONE, second op
      // accepted on the first IDLE edge.
      n1 = 6; n2 = 3;
      model(32'hDEAD_BEEF, 6, 1'b1, es, ec, eo, ee);
      model(32'h1357_9BDF, 3, 1'b0, es2, ec2, eo2, ee2);
      start = 1'b1; a = 32'hDEAD_BEEF; b = 6; arith = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = 32'h1357_9BDF; b = 3; arith = 1'b0;
      nd = 0; d1 = -1; d2 = -1;
      for (k = 1; k <= n1 + n2 + 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == n1 + 3) start = 1'b0;
         if (done) begin
            nd++;
            if (nd == 1) begin
               d1 = k;
               chk("hs.op1", {s, of, cary, eq}, {es, eo, ec, ee});
            end else if (nd == 2) begin
               d2 = k;
               chk("hs.op2", {s, of, cary, eq}, {es2, eo2, ec2, ee2});
            end
         end
      end
      chk("hs.ndone", 64'(nd), 64'd2);
      chk("hs.t1", 64'(d1), 64'(n1 + 1));
      chk("hs.t2", 64'(d2), 64'(n1 + n2 + 4));

      // Asynchronous reset in the middle of a 20-bit shift.
      start = 1'b1; a = 32'hF0F0_1234; b = 20; arith = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst.mid", {s, of, cary, eq, busy, done}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (25) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      chk("rst.nodone", 64'(nd), 64'd0);
      run_op("post", 32'h8000_0000, 31, 1'b0);
      chk("post.val", {s, of, cary}, {32'h0000_0001, 2'b00});

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       ra = '1;
            1:       ra = ra & 32'h0000_00FF;
            default: ;
         endcase
         rb = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 36));
         run_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
